// File: rtl/coffee_brewer.sv
// coffee_brewer
// Brewing-unit responder for the vending controller's make loop. One beverage
// is brewed per assertion of making (cup drop, heat, pour water, optional milk),
// then done is returned. Cup removal is reported as take_out. Both phases use
// a four-phase handshake, so a cup can never be lost or counted twice.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   making       in   request level from controller, held until done seen
//   coffee       in   controller waiting for removal, held until take_out
//   kind[1:0]    in   2'b01 Americano, 2'b10 Latte, others invalid
//   temp_ok      in   boiler at temperature
//   cup_present  in   cup sensor at dispense slot (synchronous)
//   fault_clr    in   clears the sticky fault flag
//   done         out  brew finished or aborted, held until making low
//   take_out     out  cup removed, held until coffee low
//   cup_drop     out  cup dispenser actuator
//   heater       out  boiler heater enable
//   pump_water   out  water pump enable
//   pump_milk    out  milk pump enable
//   busy         out  high in every state except IDLE
//   fault        out  sticky error flag
//   brew_count   out  completed (non-aborted) beverages, wraps at 16 bits
module coffee_brewer #(
    parameter int CUP_T   = 8,
    parameter int HEAT_TO = 64,
    parameter int POUR_AM = 32,
    parameter int POUR_LA = 24,
    parameter int MILK_T  = 16,
    parameter int DEB     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        making,
    input  logic        coffee,
    input  logic [1:0]  kind,
    input  logic        temp_ok,
    input  logic        cup_present,
    input  logic        fault_clr,
    output logic        done,
    output logic        take_out,
    output logic        cup_drop,
    output logic        heater,
    output logic        pump_water,
    output logic        pump_milk,
    output logic        busy,
    output logic        fault,
    output logic [15:0] brew_count
);

    localparam int MAX_A = (CUP_T > HEAT_TO) ? CUP_T : HEAT_TO;
    localparam int MAX_B = (POUR_AM > POUR_LA) ? POUR_AM : POUR_LA;
    localparam int MAX_C = (MILK_T > DEB) ? MILK_T : DEB;
    localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_P = (MAX_D > MAX_C) ? MAX_D : MAX_C;
    localparam int CW    = $clog2(MAX_P) + 1;

    typedef enum logic [3:0] {
        IDLE, CUP, HEAT, POUR, MILK, DONE, ABORT, TAKE, RDY
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          latte, latte_next;
    logic          brewed, brewed_next;
    logic          fault_set;
    logic          count_inc;
    logic [CW-1:0] pour_last;

    // One shared cycle counter serves every timed state; it is zeroed on
    // each transition so every state starts counting from 0.
    assign pour_last = latte ? CW'(POUR_LA - 1) : CW'(POUR_AM - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            latte      <= 1'b0;
            brewed     <= 1'b0;
            fault      <= 1'b0;
            brew_count <= 16'd0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            latte  <= latte_next;
            brewed <= brewed_next;
            // A new fault wins over a simultaneous clear.
            fault  <= fault_set | (fault & ~fault_clr);
            if (count_inc)
                brew_count <= brew_count + 16'd1;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        latte_next  = latte;
        brewed_next = brewed;
        fault_set   = 1'b0;
        count_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (making) begin
                    if (kind == 2'b01 || kind == 2'b10) begin
                        state_next = CUP;
                        cnt_next   = '0;
                        latte_next = (kind == 2'b10);
                    end else begin
                        state_next  = ABORT;
                        brewed_next = 1'b0;
                        fault_set   = 1'b1;
                    end
                end
            end
            CUP: begin
                if (cnt == CW'(CUP_T - 1)) begin
                    state_next = HEAT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            HEAT: begin
                if (temp_ok) begin
                    state_next = POUR;
                    cnt_next   = '0;
                end else if (cnt == CW'(HEAT_TO - 1)) begin
                    state_next  = ABORT;
                    brewed_next = 1'b0;
                    fault_set   = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            POUR: begin
                if (cnt == pour_last) begin
                    cnt_next = '0;
                    if (latte) begin
                        state_next = MILK;
                    end else begin
                        state_next  = DONE;
                        brewed_next = 1'b1;
                        count_inc   = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            MILK: begin
                if (cnt == CW'(MILK_T - 1)) begin
                    state_next  = DONE;
                    cnt_next    = '0;
                    brewed_next = 1'b1;
                    count_inc   = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DONE, ABORT: begin
                if (!making) begin
                    state_next = TAKE;
                    cnt_next   = '0;
                end
            end
            TAKE: begin
                // Debounce only runs while the controller is waiting; any
                // high sensor reading restarts the low-cycle count.
                if (coffee) begin
                    if (!brewed) begin
                        state_next = RDY;
                    end else if (cup_present) begin
                        cnt_next = '0;
                    end else if (cnt == CW'(DEB - 1)) begin
                        state_next = RDY;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            RDY: begin
                if (!coffee)
                    state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs decode the state register directly, so reset drops every
    // actuator asynchronously.
    always_comb begin
        done       = (state == DONE) || (state == ABORT);
        take_out   = (state == RDY);
        cup_drop   = (state == CUP);
        heater     = (state == HEAT) || (state == POUR);
        pump_water = (state == POUR);
        pump_milk  = (state == MILK);
        busy       = (state != IDLE);
    end

endmodule

// File: tb/tb_coffee_brewer.sv
// tb_coffee_brewer
// Directed-vector bench for coffee_brewer with hand-computed expectations:
// Americano and Latte brews, heat timeout, invalid kind, removal debounce,
// fault clear priority and reset during pour.
module tb_coffee_brewer;

    logic        clk;
    logic        rstN;
    logic        making;
    logic        coffee;
    logic [1:0]  kind;
    logic        tempOk;
    logic        cupPresent;
    logic        faultClr;
    logic        done;
    logic        takeOut;
    logic        cupDrop;
    logic        heater;
    logic        pumpWater;
    logic        pumpMilk;
    logic        busy;
    logic        fault;
    logic [15:0] brewCount;

    int total;
    int bad;

    int doneCyc, nCup, nWater, nMilk, nHeatOnly, nHeater, nOverlap;

    coffee_brewer dut (
        .clk         (clk),
        .rst_n       (rstN),
        .making      (making),
        .coffee      (coffee),
        .kind        (kind),
        .temp_ok     (tempOk),
        .cup_present (cupPresent),
        .fault_clr   (faultClr),
        .done        (done),
        .take_out    (takeOut),
        .cup_drop    (cupDrop),
        .heater      (heater),
        .pump_water  (pumpWater),
        .pump_milk   (pumpMilk),
        .busy        (busy),
        .fault       (fault),
        .brew_count  (brewCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change 1 time unit after the rising edge and are sampled at the next one.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic mk, input logic cf, input logic [1:0] kd,
                                 input logic tk, input logic cp, input logic fc);
        making     = mk;
        coffee     = cf;
        kind       = kd;
        tempOk     = tk;
        cupPresent = cp;
        faultClr   = fc;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Ticks until done rises or the cycle budget runs out (doneCyc stays 0 then),
    // tallying actuator cycles. Optionally raises temp_ok after heatRise HEAT
    // cycles and drops making after cycle dropAt.
    task automatic measure(input int maxCyc, input int dropAt, input int heatRise);
        doneCyc = 0; nCup = 0; nWater = 0; nMilk = 0;
        nHeatOnly = 0; nHeater = 0; nOverlap = 0;
        for (int c = 1; c <= maxCyc; c++) begin
            tick();
            if (cupDrop) nCup++;
            if (pumpWater) nWater++;
            if (pumpMilk) nMilk++;
            if (heater) nHeater++;
            if (heater && !pumpWater) nHeatOnly++;
            if (pumpWater && pumpMilk) nOverlap++;
            if (done) begin
                doneCyc = c;
                break;
            end
            if (heatRise > 0 && nHeatOnly == heatRise) tempOk = 1'b1;
            if (c == dropAt) making = 1'b0;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstN  = 1'b0;
        applyStimulus(0, 0, 2'b00, 0, 1, 0);
        #23;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_fault", int'(fault), 0);
        checkOutput("rst_count", int'(brewCount), 0);
        checkOutput("rst_act", int'({cupDrop, heater, pumpWater, pumpMilk, takeOut}), 0);
        @(negedge clk);
        rstN = 1'b1;
        tick();

        // Americano with boiler already hot
        applyStimulus(1, 0, 2'b01, 1, 1, 0);
        measure(100, 0, 0);
        checkOutput("am_done_cyc", doneCyc, 42);
        checkOutput("am_cup", nCup, 8);
        checkOutput("am_water", nWater, 32);
        checkOutput("am_heater", nHeater, 33);
        checkOutput("am_milk", nMilk, 0);
        checkOutput("am_count", int'(brewCount), 1);
        tick(2);
        checkOutput("am_done_held", int'(done), 1);
        making = 1'b0;
        tick();
        checkOutput("am_take_done", int'(done), 0);
        checkOutput("am_take_busy", int'(busy), 1);

        // Removal debounce: low 3, high 1, low 4
        applyStimulus(0, 1, 2'b01, 1, 0, 0);
        tick(3);
        cupPresent = 1'b1;
        tick();
        cupPresent = 1'b0;
        tick(3);
        checkOutput("deb_early", int'(takeOut), 0);
        tick();
        checkOutput("deb_take", int'(takeOut), 1);
        tick();
        checkOutput("deb_hold", int'(takeOut), 1);
        coffee = 1'b0;
        tick();
        checkOutput("deb_idle_busy", int'(busy), 0);
        checkOutput("deb_idle_take", int'(takeOut), 0);

        // Latte, kind changed mid-brew, temp_ok rises after 10 HEAT cycles
        applyStimulus(1, 0, 2'b10, 0, 1, 0);
        tick();
        checkOutput("la_cup_first", int'(cupDrop), 1);
        kind = 2'b01;
        measure(200, 0, 10);
        checkOutput("la_done_cyc", doneCyc, 58);
        checkOutput("la_cup", nCup, 7);
        checkOutput("la_heat", nHeatOnly, 10);
        checkOutput("la_water", nWater, 24);
        checkOutput("la_milk", nMilk, 16);
        checkOutput("la_overlap", nOverlap, 0);
        checkOutput("la_count", int'(brewCount), 2);
        tick(3);
        checkOutput("la_done_held", int'(done), 1);
        making = 1'b0;
        tick();
        checkOutput("la_take_done", int'(done), 0);
        checkOutput("la_take_busy", int'(busy), 1);
        applyStimulus(0, 1, 2'b01, 0, 0, 0);
        tick(4);
        checkOutput("la_takeout", int'(takeOut), 1);
        coffee = 1'b0;
        tick();
        checkOutput("la_idle", int'(busy), 0);

        // Heat timeout
        applyStimulus(1, 0, 2'b01, 0, 1, 0);
        measure(120, 0, 0);
        checkOutput("to_done_cyc", doneCyc, 73);
        checkOutput("to_heater", nHeater, 64);
        checkOutput("to_water", nWater, 0);
        checkOutput("to_fault", int'(fault), 1);
        checkOutput("to_count", int'(brewCount), 2);
        making = 1'b0;
        tick();
        checkOutput("to_take_done", int'(done), 0);
        coffee = 1'b1;
        tick();
        checkOutput("to_takeout", int'(takeOut), 1);
        coffee = 1'b0;
        tick();
        checkOutput("to_idle", int'(busy), 0);
        checkOutput("to_fault_sticky", int'(fault), 1);
        faultClr = 1'b1;
        tick();
        faultClr = 1'b0;
        checkOutput("to_fault_clr", int'(fault), 0);

        // Invalid kind aborts without touching any actuator
        applyStimulus(1, 0, 2'b11, 1, 1, 0);
        measure(10, 0, 0);
        checkOutput("inv_done_cyc", doneCyc, 1);
        checkOutput("inv_act", nCup + nWater + nMilk + nHeater, 0);
        checkOutput("inv_fault", int'(fault), 1);
        checkOutput("inv_count", int'(brewCount), 2);
        making = 1'b0;
        tick();
        coffee = 1'b1;
        tick();
        coffee = 1'b0;
        tick();
        checkOutput("inv_idle", int'(busy), 0);

        // Clear and new fault in the same cycle: fault stays set
        applyStimulus(1, 0, 2'b11, 1, 1, 1);
        tick();
        checkOutput("clr_vs_set", int'(fault), 1);
        checkOutput("clr_vs_set_done", int'(done), 1);
        applyStimulus(0, 0, 2'b11, 1, 1, 1);
        tick();
        checkOutput("clr_after", int'(fault), 0);
        applyStimulus(0, 1, 2'b01, 1, 1, 0);
        tick();
        coffee = 1'b0;
        tick();

        // Reset during POUR, then a normal brew with making dropped early
        applyStimulus(1, 0, 2'b01, 1, 1, 0);
        tick(12);
        checkOutput("rp_pour", int'(pumpWater), 1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("rp_water", int'(pumpWater), 0);
        checkOutput("rp_heater", int'(heater), 0);
        checkOutput("rp_busy", int'(busy), 0);
        checkOutput("rp_count", int'(brewCount), 0);
        making = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        tick();
        applyStimulus(1, 0, 2'b01, 1, 1, 0);
        measure(100, 5, 0);
        checkOutput("rp_done_cyc", doneCyc, 42);
        checkOutput("rp_water_cnt", nWater, 32);
        checkOutput("rp_count_after", int'(brewCount), 1);
        tick();
        checkOutput("rp_early_drop_done", int'(done), 0);
        checkOutput("rp_early_drop_busy", int'(busy), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
